// File: rtl/rs_slot_pkg.sv
// rtl/rs_slot_pkg.sv - shared payload layout and state encoding for reservation-station slots
// Used by rs_slot and by the dispatch stage that builds the payload.
package rs_slot_pkg;

  localparam int RS_PAYLOAD_W     = 76;
  localparam int RS_TAG_W_DEFAULT = 6;
  localparam int RS_V_W           = 32;
  localparam int RS_RD_W          = 5;
  localparam int RS_ALU_W         = 5;

  // {rs2_v[32], rs2_ok, rs1_v[32], rs1_ok, rd[5], alu_ctrl[5]}
  localparam int RS_ALU_LSB    = 0;
  localparam int RS_RD_LSB     = 5;
  localparam int RS_RS1_OK_BIT = 10;
  localparam int RS_RS1_V_LSB  = 11;
  localparam int RS_RS2_OK_BIT = 43;
  localparam int RS_RS2_V_LSB  = 44;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } rs_state_e;

endpackage

// File: rtl/rs_operand_snoop.sv
// rtl/rs_operand_snoop.sv - resolves one source operand against both CDB broadcast ports
// Port 0 wins when both ports carry the operand's tag; ok operands pass through untouched.
module rs_operand_snoop #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic              i_ok,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_cdb0_valid,
  input  logic [TAG_W-1:0]  i_cdb0_tag,
  input  logic [DATA_W-1:0] i_cdb0_data,
  input  logic              i_cdb1_valid,
  input  logic [TAG_W-1:0]  i_cdb1_tag,
  input  logic [DATA_W-1:0] i_cdb1_data,
  output logic              o_ok,
  output logic [DATA_W-1:0] o_value
);

  logic [TAG_W-1:0] w_tag;
  logic             w_hit0;
  logic             w_hit1;

  assign w_tag  = i_value[TAG_W-1:0];
  assign w_hit0 = !i_ok && i_cdb0_valid && (i_cdb0_tag == w_tag);
  assign w_hit1 = !i_ok && i_cdb1_valid && (i_cdb1_tag == w_tag);

  always_comb begin
    o_ok    = i_ok;
    o_value = i_value;
    if (w_hit0) begin
      o_ok    = 1'b1;
      o_value = i_cdb0_data;
    end else if (w_hit1) begin
      o_ok    = 1'b1;
      o_value = i_cdb1_data;
    end
  end

endmodule

// File: rtl/rs_slot.sv
// rtl/rs_slot.sv - single-entry reservation-station slot with CDB wakeup and valid/ready issue
// Optional same-cycle issue from dispatch when RS_ISSUE_BYPASS_EN is defined.
module rs_slot
  import rs_slot_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = RS_TAG_W_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_in_valid,
  input  logic [RS_PAYLOAD_W-1:0] i_in_data,
  input  logic                    i_cdb0_valid,
  input  logic [TAG_W-1:0]        i_cdb0_tag,
  input  logic [DATA_W-1:0]       i_cdb0_data,
  input  logic                    i_cdb1_valid,
  input  logic [TAG_W-1:0]        i_cdb1_tag,
  input  logic [DATA_W-1:0]       i_cdb1_data,
  input  logic                    i_fu_ready,
  output logic                    o_empty,
  output logic                    o_issue_valid,
  output logic [DATA_W-1:0]       o_issue_rs1,
  output logic [DATA_W-1:0]       o_issue_rs2,
  output logic [RS_RD_W-1:0]      o_issue_rd,
  output logic [RS_ALU_W-1:0]     o_issue_alu_ctrl
);

  rs_state_e             r_state;
  logic                  r_empty;
  logic                  r_issue_valid;
  logic                  r_rs1_ok;
  logic                  r_rs2_ok;
  logic [DATA_W-1:0]     r_rs1_v;
  logic [DATA_W-1:0]     r_rs2_v;
  logic [RS_RD_W-1:0]    r_rd;
  logic [RS_ALU_W-1:0]   r_alu;

  logic                  w_src_rs1_ok;
  logic                  w_src_rs2_ok;
  logic [DATA_W-1:0]     w_src_rs1_v;
  logic [DATA_W-1:0]     w_src_rs2_v;
  logic                  w_rs1_ok;
  logic                  w_rs2_ok;
  logic [DATA_W-1:0]     w_rs1_v;
  logic [DATA_W-1:0]     w_rs2_v;
  logic [RS_RD_W-1:0]    w_in_rd;
  logic [RS_ALU_W-1:0]   w_in_alu;
  logic                  w_bypass;

  // The same snoopers serve capture (payload operands) and wakeup (stored operands).
  assign w_src_rs1_ok = (r_state == EMPTY) ? i_in_data[RS_RS1_OK_BIT] : r_rs1_ok;
  assign w_src_rs2_ok = (r_state == EMPTY) ? i_in_data[RS_RS2_OK_BIT] : r_rs2_ok;
  assign w_src_rs1_v  = (r_state == EMPTY) ? DATA_W'(i_in_data[RS_RS1_V_LSB +: RS_V_W]) : r_rs1_v;
  assign w_src_rs2_v  = (r_state == EMPTY) ? DATA_W'(i_in_data[RS_RS2_V_LSB +: RS_V_W]) : r_rs2_v;
  assign w_in_rd      = i_in_data[RS_RD_LSB +: RS_RD_W];
  assign w_in_alu     = i_in_data[RS_ALU_LSB +: RS_ALU_W];

  rs_operand_snoop #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_snoop_rs1 (
    .i_ok         (w_src_rs1_ok),
    .i_value      (w_src_rs1_v),
    .i_cdb0_valid (i_cdb0_valid),
    .i_cdb0_tag   (i_cdb0_tag),
    .i_cdb0_data  (i_cdb0_data),
    .i_cdb1_valid (i_cdb1_valid),
    .i_cdb1_tag   (i_cdb1_tag),
    .i_cdb1_data  (i_cdb1_data),
    .o_ok         (w_rs1_ok),
    .o_value      (w_rs1_v)
  );

  rs_operand_snoop #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_snoop_rs2 (
    .i_ok         (w_src_rs2_ok),
    .i_value      (w_src_rs2_v),
    .i_cdb0_valid (i_cdb0_valid),
    .i_cdb0_tag   (i_cdb0_tag),
    .i_cdb0_data  (i_cdb0_data),
    .i_cdb1_valid (i_cdb1_valid),
    .i_cdb1_tag   (i_cdb1_tag),
    .i_cdb1_data  (i_cdb1_data),
    .o_ok         (w_rs2_ok),
    .o_value      (w_rs2_v)
  );

`ifdef RS_ISSUE_BYPASS_EN
  assign w_bypass = (r_state == EMPTY) && i_in_valid && !i_flush &&
                    w_rs1_ok && w_rs2_ok && i_fu_ready;
  assign o_issue_valid    = w_bypass | r_issue_valid;
  assign o_issue_rs1      = w_bypass ? w_rs1_v  : r_rs1_v;
  assign o_issue_rs2      = w_bypass ? w_rs2_v  : r_rs2_v;
  assign o_issue_rd       = w_bypass ? w_in_rd  : r_rd;
  assign o_issue_alu_ctrl = w_bypass ? w_in_alu : r_alu;
`else
  assign w_bypass         = 1'b0;
  assign o_issue_valid    = r_issue_valid;
  assign o_issue_rs1      = r_rs1_v;
  assign o_issue_rs2      = r_rs2_v;
  assign o_issue_rd       = r_rd;
  assign o_issue_alu_ctrl = r_alu;
`endif

  assign o_empty = r_empty;

  // Stored fields are zeroed whenever the slot empties so the issue outputs read 0 in EMPTY.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_state       <= EMPTY;
      r_empty       <= 1'b1;
      r_issue_valid <= 1'b0;
      r_rs1_ok      <= 1'b0;
      r_rs2_ok      <= 1'b0;
      r_rs1_v       <= '0;
      r_rs2_v       <= '0;
      r_rd          <= '0;
      r_alu         <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_in_valid && !w_bypass) begin
            r_rs1_ok      <= w_rs1_ok;
            r_rs2_ok      <= w_rs2_ok;
            r_rs1_v       <= w_rs1_v;
            r_rs2_v       <= w_rs2_v;
            r_rd          <= w_in_rd;
            r_alu         <= w_in_alu;
            r_empty       <= 1'b0;
            r_issue_valid <= w_rs1_ok && w_rs2_ok;
            r_state       <= (w_rs1_ok && w_rs2_ok) ? READY : WAIT;
          end
        end
        WAIT: begin
          r_rs1_ok <= w_rs1_ok;
          r_rs2_ok <= w_rs2_ok;
          r_rs1_v  <= w_rs1_v;
          r_rs2_v  <= w_rs2_v;
          if (w_rs1_ok && w_rs2_ok) begin
            r_issue_valid <= 1'b1;
            r_state       <= READY;
          end
        end
        READY: begin
          if (i_fu_ready) begin
            r_state       <= EMPTY;
            r_empty       <= 1'b1;
            r_issue_valid <= 1'b0;
            r_rs1_ok      <= 1'b0;
            r_rs2_ok      <= 1'b0;
            r_rs1_v       <= '0;
            r_rs2_v       <= '0;
            r_rd          <= '0;
            r_alu         <= '0;
          end
        end
        default: begin
          r_state       <= EMPTY;
          r_empty       <= 1'b1;
          r_issue_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_slot.sv
// tb/tb_rs_slot.sv - directed scoreboard bench for rs_slot (default build, bypass macro undefined)
module tb_rs_slot;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [75:0] in_data;
  logic        cdb0_valid, cdb1_valid;
  logic [5:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_data, cdb1_data;
  logic        fu_ready;
  logic        empty, issue_valid;
  logic [31:0] issue_rs1, issue_rs2;
  logic [4:0]  issue_rd, issue_alu_ctrl;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [4:0]  alu;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rs_slot u_dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_flush          (flush),
    .i_in_valid       (in_valid),
    .i_in_data        (in_data),
    .i_cdb0_valid     (cdb0_valid),
    .i_cdb0_tag       (cdb0_tag),
    .i_cdb0_data      (cdb0_data),
    .i_cdb1_valid     (cdb1_valid),
    .i_cdb1_tag       (cdb1_tag),
    .i_cdb1_data      (cdb1_data),
    .i_fu_ready       (fu_ready),
    .o_empty          (empty),
    .o_issue_valid    (issue_valid),
    .o_issue_rs1      (issue_rs1),
    .o_issue_rs2      (issue_rs2),
    .o_issue_rd       (issue_rd),
    .o_issue_alu_ctrl (issue_alu_ctrl)
  );

  function automatic logic [75:0] mk(input logic [31:0] rs2_v, input logic rs2_ok,
                                     input logic [31:0] rs1_v, input logic rs1_ok,
                                     input logic [4:0] rd, input logic [4:0] alu);
    return {rs2_v, rs2_ok, rs1_v, rs1_ok, rd, alu};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A transfer happens at the next rising edge when both are high.
  always @(negedge clk) begin
    if (rst_n && issue_valid && fu_ready) begin
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("issue_rs1", 64'(issue_rs1), 64'(e.rs1));
        check("issue_rs2", 64'(issue_rs2), 64'(e.rs2));
        check("issue_rd", 64'(issue_rd), 64'(e.rd));
        check("issue_alu", 64'(issue_alu_ctrl), 64'(e.alu));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; fu_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h1, 1'b1, 32'h2, 1'b1, 5'd1, 5'd1);
    cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
    cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;

    // Reset held with dispatch strobing
    step(); step();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_data", {issue_rs1, issue_rs2}, 64'd0);
    check("rst_rd_alu", 64'({issue_rd, issue_alu_ctrl}), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();

    // Both operands ready at dispatch
    in_valid = 1'b1; fu_ready = 1'b1;
    in_data = mk(32'h22, 1'b1, 32'h11, 1'b1, 5'd3, 5'd5);
    sb.push_back('{rs1: 32'h11, rs2: 32'h22, rd: 5'd3, alu: 5'd5});
    step();
    in_valid = 1'b0;
    check("t2_issue_valid", 64'(issue_valid), 64'd1);
    check("t2_empty_busy", 64'(empty), 64'd0);
    step();
    check("t2_empty_after", 64'(empty), 64'd1);
    check("t2_valid_after", 64'(issue_valid), 64'd0);
    check("t2_data_zero", 64'(issue_rs1), 64'd0);

    // CDB wakeup, both ports match rs1: port 0 wins
    in_valid = 1'b1;
    in_data = mk(32'h5, 1'b1, 32'h7, 1'b0, 5'd1, 5'd2);
    step();
    in_valid = 1'b0;
    check("t3_wait_valid", 64'(issue_valid), 64'd0);
    check("t3_wait_empty", 64'(empty), 64'd0);
    step();
    check("t3_wait_valid2", 64'(issue_valid), 64'd0);
    cdb0_valid = 1'b1; cdb0_tag = 6'd7; cdb0_data = 32'hAA;
    cdb1_valid = 1'b1; cdb1_tag = 6'd7; cdb1_data = 32'hBB;
    sb.push_back('{rs1: 32'hAA, rs2: 32'h5, rd: 5'd1, alu: 5'd2});
    step();
    cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    check("t3_woken_valid", 64'(issue_valid), 64'd1);
    check("t3_port0_wins", 64'(issue_rs1), 64'hAA);
    step();
    check("t3_empty_after", 64'(empty), 64'd1);

    // Same-cycle wakeup of both operands from port 1, then back-pressure
    fu_ready = 1'b0; in_valid = 1'b1;
    in_data = mk(32'h4, 1'b0, 32'h4, 1'b0, 5'd7, 5'd9);
    cdb1_valid = 1'b1; cdb1_tag = 6'd4; cdb1_data = 32'h99;
    sb.push_back('{rs1: 32'h99, rs2: 32'h99, rd: 5'd7, alu: 5'd9});
    step();
    in_valid = 1'b0; cdb1_valid = 1'b0;
    check("t4_ready", 64'(issue_valid), 64'd1);
    check("t4_ops", {issue_rs1, issue_rs2}, {32'h99, 32'h99});
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_valid", 64'(issue_valid), 64'd1);
      check("t4_hold_ops", {issue_rs1, issue_rs2}, {32'h99, 32'h99});
      check("t4_hold_rd_alu", 64'({issue_rd, issue_alu_ctrl}), 64'({5'd7, 5'd9}));
    end
    fu_ready = 1'b1;
    step();
    check("t4_empty_after", 64'(empty), 64'd1);

    // Flush in WAIT beats a matching CDB
    in_valid = 1'b1;
    in_data = mk(32'h1, 1'b1, 32'h9, 1'b0, 5'd4, 5'd4);
    step();
    in_valid = 1'b0;
    flush = 1'b1; cdb0_valid = 1'b1; cdb0_tag = 6'd9; cdb0_data = 32'h55;
    step();
    flush = 1'b0; cdb0_valid = 1'b0;
    check("t5_flush_empty", 64'(empty), 64'd1);
    check("t5_flush_no_issue", 64'(issue_valid), 64'd0);
    step();
    check("t5_still_idle", 64'(issue_valid), 64'd0);
    // Flush with dispatch in EMPTY blocks capture
    flush = 1'b1; in_valid = 1'b1;
    in_data = mk(32'h3, 1'b1, 32'h3, 1'b1, 5'd3, 5'd3);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_no_capture_empty", 64'(empty), 64'd1);
    check("t5_no_capture_valid", 64'(issue_valid), 64'd0);
    check("t5_no_capture_data", {issue_rs1, issue_rs2}, 64'd0);

    // Dispatch into a READY slot is ignored
    fu_ready = 1'b0; in_valid = 1'b1;
    in_data = mk(32'h44, 1'b1, 32'h33, 1'b1, 5'd2, 5'd6);
    sb.push_back('{rs1: 32'h33, rs2: 32'h44, rd: 5'd2, alu: 5'd6});
    step();
    in_data = mk(32'hAD, 1'b1, 32'hDE, 1'b1, 5'd31, 5'd31);
    step();
    in_valid = 1'b0;
    check("t6_rs_kept", {issue_rs1, issue_rs2}, {32'h33, 32'h44});
    check("t6_rd_alu_kept", 64'({issue_rd, issue_alu_ctrl}), 64'({5'd2, 5'd6}));
    fu_ready = 1'b1;
    step();
    check("t6_empty_after", 64'(empty), 64'd1);
    step();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
